tri_mon: RTL and testbench
==========================

// Module: tri_mon
// PURPOSE
//  Receive-side monitor for the 9-bit trapezoid/triangle sample stream (rise, flat top, fall, flat bottom).
//  Samples d_in every clk, locks onto the waveform, measures each period and reports peak, dwell lengths and period.
//  Flags any sample step that is not +1, 0 or -1 in the legal order.
//  Sits downstream of the waveform source as its self-check / measurement end.
// PARAMETERS
//  DW  9   sample width
//  CW  12  width of every length/period counter (saturating)
//  EW  8   width of err_cnt (saturating)
// PORTS
//  clk      in   1   single clock, rising edge
//  res      in   1   asynchronous, active-low reset
//  d_in     in   DW  sample stream, one sample per clk
//  locked   out  1   1 when FSM is not in SYNC
//  done     out  1   1-cycle pulse: a full period has been measured, result regs updated
//  peak     out  DW  top value of the last completed period
//  top_len  out  CW  cycles d_in held the peak value
//  bot_len  out  CW  cycles d_in held the bottom value
//  period   out  CW  cycles between two consecutive rise starts
//  err      out  1   1-cycle pulse on illegal step
//  err_cnt  out  EW  saturating count of err pulses since reset
// BEHAVIOUR
//  - Reset (res=0, async): state=SYNC, prev=0, all counters 0, every output 0.
//  - prev <= d_in each clk. Class from (d_in - prev) in DW+1 bits: UP=+1, FLAT=0, DN=-1, JUMP=other.
//    Wrap 511->0 or 0->511 is JUMP.
//  - FSM, evaluated on the class of the current sample:
//    SYNC: UP -> RISE, per_cnt<=1. Anything else stays; no err in SYNC.
//    RISE: UP stay, pk<=d_in; FLAT -> TOP, t_cnt<=2; DN/JUMP -> err, SYNC.
//    TOP:  FLAT stay, t_cnt+1; DN -> FALL; UP/JUMP -> err, SYNC.
//    FALL: DN stay; FLAT -> BOT, b_cnt<=2; UP/JUMP -> err, SYNC.
//    BOT:  FLAT stay, b_cnt+1; UP -> RISE, done<=1, peak<=pk, top_len<=t_cnt, bot_len<=b_cnt,
//          period<=per_cnt, per_cnt<=1; DN/JUMP -> err, SYNC.
//  - per_cnt +1 every clk outside SYNC, except the clk it is reloaded to 1.
//  - t_cnt, b_cnt, per_cnt saturate at 2^CW-1; err_cnt saturates at 2^EW-1.
//  - Outputs are registered: done/err assert the clk after the triggering sample edge (latency 1).
//    Result regs hold until the next done.
//  - On err: the partial period is discarded. Result regs keep their last values; per_cnt clears.
//  - A direct RISE->FALL transition (no flat top) is illegal: err.
//  - Reset mid-operation clears everything. The first done after reset needs one full period after the first UP.
// STRUCTURE
//  - Shared package/header: state codes (SYNC=0, RISE=1, TOP=2, FALL=3, BOT=4; 3-bit),
//    slope class codes (UP, FLAT, DN, JUMP; 2-bit).
//  - One sub-module, tri_slope_cls: registers prev and outputs the 2-bit class. The FSM and counters live in tri_mon.
// TESTING
//  1. Source 0..300 rise, 300 held 202 clk, fall to 0, 0 held 202 clk, repeating.
//     -> from 2nd rise start: done each period; peak=300, top_len=202, bot_len=202, period=1002; err never.
//  2. Sequence 0,0,1,2,2,1,0,0,1 -> one done: peak=2, top_len=2, bot_len=2, period=6.
//  3. Step +2 at value 100 during rise -> err pulse, err_cnt=1, locked=0.
//     No done until a full clean period after the next UP; results then match case 1.
//  4. res pulled low during TOP -> all outputs 0 immediately.
//     After release: locked=0 until first UP; done only after one full period.
//  5. Peak held 5000 clk (CW=12) -> top_len=4095, period=4095; no err.
//  6. Step 511->0 during FALL -> classified JUMP: err, SYNC.
//     Then 300 illegal steps in SYNC -> err_cnt stays 1.

Source files
------------

// File: rtl/tri_mon_pkg.sv
// Shared encodings for the trapezoid/triangle stream monitor:
// FSM state codes and the 2-bit sample-step classes.
package tri_mon_pkg;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_RISE = 3'd1,
    ST_TOP  = 3'd2,
    ST_FALL = 3'd3,
    ST_BOT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CL_UP   = 2'd0,
    CL_FLAT = 2'd1,
    CL_DN   = 2'd2,
    CL_JUMP = 2'd3
  } slope_t;

endpackage

// File: rtl/tri_slope_cls.sv
// Step classifier: keeps the previous sample and classifies the step to the
// current sample as +1, 0, -1 or anything else. The difference is taken one
// bit wider than the sample so that 511->0 and 0->511 land in JUMP.
module tri_slope_cls
  import tri_mon_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          res,
  input  logic [DW-1:0] i_d,
  output slope_t        o_cls
);

  logic [DW-1:0] r_prev;
  logic [DW:0]   w_diff;

  // Previous-sample register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge res) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!res) r_prev <= '0;
    else      r_prev <= i_d;
  end

  assign w_diff = {1'b0, i_d} - {1'b0, r_prev};

  // Map the widened difference onto the four step classes.
  always_comb begin
    // NOTE: default first so no path leaves o_cls unassigned (no latch).
    o_cls = CL_JUMP;
    if (w_diff == (DW+1)'(1))       o_cls = CL_UP;
    else if (w_diff == '0)          o_cls = CL_FLAT;
    else if (w_diff == '1)          o_cls = CL_DN;
  end

endmodule

// File: rtl/tri_mon.sv
// Receive-side monitor for a trapezoid/triangle sample stream. Locks on the
// first rising step, walks RISE -> TOP -> FALL -> BOT, measures the flat
// dwell lengths and the rise-to-rise period, and flags illegal steps.
module tri_mon
  import tri_mon_pkg::*;
#(
  parameter int DW = 9,
  parameter int CW = 12,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          res,
  input  logic [DW-1:0] d_in,
  output logic          locked,
  output logic          done,
  output logic [DW-1:0] peak,
  output logic [CW-1:0] top_len,
  output logic [CW-1:0] bot_len,
  output logic [CW-1:0] period,
  output logic          err,
  output logic [EW-1:0] err_cnt
);

  slope_t        w_cls;
  state_t        r_state, w_state_nxt;

  logic          w_start;   // (re)start of a period: per_cnt reloads to 1
  logic          w_pk_ld;   // capture current sample as running peak
  logic          w_t_ld, w_t_inc;
  logic          w_b_ld, w_b_inc;
  logic          w_done, w_err;

  logic [DW-1:0] r_pk;
  logic [CW-1:0] r_t_cnt, r_b_cnt, r_per_cnt;
  logic          r_done, r_err;
  logic [EW-1:0] r_err_cnt;
  logic [DW-1:0] r_peak;
  logic [CW-1:0] r_top_len, r_bot_len, r_period;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  tri_slope_cls #(.DW(DW)) u_cls (
    .clk   (clk),
    .res   (res),
    .i_d   (d_in),
    .o_cls (w_cls)
  );

  // State register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= ST_SYNC;
    else      r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes from the current state and step class.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_pk_ld     = 1'b0;
    w_t_ld      = 1'b0;
    w_t_inc     = 1'b0;
    w_b_ld      = 1'b0;
    w_b_inc     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_SYNC: begin
        // Illegal steps are ignored while hunting for the first rise.
        if (w_cls == CL_UP) begin
          w_state_nxt = ST_RISE;
          w_start     = 1'b1;
          w_pk_ld     = 1'b1;
        end
      end
      ST_RISE: begin
        case (w_cls)
          CL_UP:   w_pk_ld = 1'b1;
          CL_FLAT: begin
            w_state_nxt = ST_TOP;
            w_t_ld      = 1'b1;
          end
          // A fall straight out of the rise (no flat top) is illegal too.
          default: begin
            w_state_nxt = ST_SYNC;
            w_err       = 1'b1;
          end
        endcase
      end
      ST_TOP: begin
        case (w_cls)
          CL_FLAT: w_t_inc     = 1'b1;
          CL_DN:   w_state_nxt = ST_FALL;
          default: begin
            w_state_nxt = ST_SYNC;
            w_err       = 1'b1;
          end
        endcase
      end
      ST_FALL: begin
        case (w_cls)
          CL_DN:   ;
          CL_FLAT: begin
            w_state_nxt = ST_BOT;
            w_b_ld      = 1'b1;
          end
          default: begin
            w_state_nxt = ST_SYNC;
            w_err       = 1'b1;
          end
        endcase
      end
      ST_BOT: begin
        case (w_cls)
          CL_FLAT: w_b_inc = 1'b1;
          CL_UP: begin
            w_state_nxt = ST_RISE;
            w_start     = 1'b1;
            w_pk_ld     = 1'b1;
            w_done      = 1'b1;
          end
          default: begin
            w_state_nxt = ST_SYNC;
            w_err       = 1'b1;
          end
        endcase
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  // Running peak and saturating dwell/period counters for the current period.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_pk      <= '0;
      r_t_cnt   <= '0;
      r_b_cnt   <= '0;
      r_per_cnt <= '0;
    end else begin
      if (w_pk_ld) r_pk <= d_in;

      // The flat segment is first seen on its second sample, hence load 2.
      if (w_t_ld)       r_t_cnt <= CW'(2);
      else if (w_t_inc) r_t_cnt <= sat_inc(r_t_cnt);

      if (w_b_ld)       r_b_cnt <= CW'(2);
      else if (w_b_inc) r_b_cnt <= sat_inc(r_b_cnt);

      // An error discards the partial period.
      if (w_start)                  r_per_cnt <= CW'(1);
      else if (w_err)               r_per_cnt <= '0;
      else if (r_state != ST_SYNC)  r_per_cnt <= sat_inc(r_per_cnt);
    end
  end

  // Registered pulses, saturating error count and the held result registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_peak    <= '0;
      r_top_len <= '0;
      r_bot_len <= '0;
      r_period  <= '0;
    end else begin
      r_done <= w_done;
      r_err  <= w_err;
      if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + EW'(1);
      if (w_done) begin
        r_peak    <= r_pk;
        r_top_len <= r_t_cnt;
        r_bot_len <= r_b_cnt;
        r_period  <= r_per_cnt;
      end
    end
  end

  assign locked  = (r_state != ST_SYNC);
  assign done    = r_done;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign peak    = r_peak;
  assign top_len = r_top_len;
  assign bot_len = r_bot_len;
  assign period  = r_period;

endmodule

// File: tb/tb_tri_mon.sv
// Directed bench for tri_mon: a per-cycle vector table for the short
// sequence, plus generated waveforms for the long multi-cycle cases.
module tb_tri_mon;

  logic        clk;
  logic        res;
  logic [8:0]  d_in;
  logic        locked, done, err;
  logic [8:0]  peak;
  logic [11:0] top_len, bot_len, period;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done, n_err;
  int e_peak, e_top, e_bot, e_per;

  typedef struct {
    logic [8:0] d;
    logic       l;
    logic       dn;
    logic       er;
  } vec_t;

  vec_t tbl [12];

  tri_mon dut (
    .clk     (clk),
    .res     (res),
    .d_in    (d_in),
    .locked  (locked),
    .done    (done),
    .peak    (peak),
    .top_len (top_len),
    .bot_len (bot_len),
    .period  (period),
    .err     (err),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    res = 1'b0;
    d_in = 9'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    n_done = 0;
    n_err  = 0;
  endtask

  // Drive one sample, sample outputs 1 time unit after the edge.
  task automatic step(input logic [8:0] d);
    d_in = d;
    @(posedge clk);
    #1;
    if (done) begin
      n_done++;
      check("done_peak", peak, e_peak);
      check("done_top_len", top_len, e_top);
      check("done_bot_len", bot_len, e_bot);
      check("done_period", period, e_per);
    end
    if (err) n_err++;
  endtask

  // One waveform period starting just after a bottom sample of 0.
  task automatic gen_cycle(input int pk, input int th, input int bh);
    for (int v = 1; v <= pk; v++) step(9'(v));
    repeat (th - 1) step(9'(pk));
    for (int v = pk - 1; v >= 0; v--) step(9'(v));
    repeat (bh - 1) step(9'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},  locked,  0);
    check({tag, "_done"},    done,    0);
    check({tag, "_err"},     err,     0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_peak"},    peak,    0);
    check({tag, "_top_len"}, top_len, 0);
    check({tag, "_bot_len"}, bot_len, 0);
    check({tag, "_period"},  period,  0);
  endtask

  initial begin
    tbl[0]  = '{9'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{9'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{9'd1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{9'd2, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{9'd2, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{9'd1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{9'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{9'd0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{9'd1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{9'd1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{9'd3, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{9'd3, 1'b0, 1'b0, 1'b0};

    res  = 1'b0;
    d_in = 9'd0;
    #2;
    check_all_zero("rst");

    // Short sequence 0,0,1,2,2,1,0,0,1 then a +2 jump out of TOP.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      d_in = tbl[i].d;
      @(posedge clk);
      #1;
      check($sformatf("seq_locked[%0d]", i), locked, tbl[i].l);
      check($sformatf("seq_done[%0d]", i),   done,   tbl[i].dn);
      check($sformatf("seq_err[%0d]", i),    err,    tbl[i].er);
    end
    check("seq_peak", peak, 2);
    check("seq_top_len", top_len, 2);
    check("seq_bot_len", bot_len, 2);
    check("seq_period", period, 6);
    check("seq_err_cnt", err_cnt, 1);

    // Clean 0..300 trapezoid, three full periods.
    e_peak = 300; e_top = 202; e_bot = 202; e_per = 1002;
    do_reset();
    repeat (5) step(9'd0);
    repeat (3) gen_cycle(300, 202, 202);
    step(9'd1);
    check("trap_done_count", n_done, 3);
    check("trap_err_count", n_err, 0);
    check("trap_locked", locked, 1);

    // +2 step at 100 during the rise, then one clean period.
    do_reset();
    repeat (3) step(9'd0);
    for (int v = 1; v <= 99; v++) step(9'(v));
    step(9'd101);
    check("jump_err", err, 1);
    check("jump_locked", locked, 0);
    check("jump_err_cnt", err_cnt, 1);
    repeat (10) step(9'd0);
    gen_cycle(300, 202, 202);
    check("jump_no_early_done", n_done, 0);
    step(9'd1);
    check("jump_done_count", n_done, 1);
    check("jump_err_count", n_err, 1);

    // Reset pulled in the middle of a TOP dwell.
    do_reset();
    step(9'd0); step(9'd1); step(9'd5);
    repeat (3) step(9'd0);
    gen_cycle(300, 202, 202);
    step(9'd1);
    for (int v = 2; v <= 300; v++) step(9'(v));
    repeat (10) step(9'd300);
    check("midrst_pre_err_cnt", err_cnt, 1);
    check("midrst_pre_peak", peak, 300);
    #2;
    res = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    res = 1'b1;
    n_done = 0;
    n_err  = 0;
    step(9'd300);
    check("midrst_locked_a", locked, 0);
    repeat (3) step(9'd0);
    check("midrst_locked_b", locked, 0);
    gen_cycle(300, 202, 202);
    check("midrst_locked_c", locked, 1);
    check("midrst_no_early_done", n_done, 0);
    step(9'd1);
    check("midrst_done_count", n_done, 1);
    check("midrst_err_count", n_err, 0);

    // Long top dwell saturates the 12-bit counters.
    e_peak = 10; e_top = 4095; e_bot = 20; e_per = 4095;
    do_reset();
    repeat (3) step(9'd0);
    gen_cycle(10, 5000, 20);
    step(9'd1);
    check("sat_done_count", n_done, 1);
    check("sat_err_count", n_err, 0);

    // Wrap steps are JUMPs; illegal steps in SYNC never count.
    do_reset();
    step(9'd500);
    check("wrap_sync_err", err, 0);
    for (int v = 501; v <= 511; v++) step(9'(v));
    check("wrap_locked_pre", locked, 1);
    step(9'd0);
    check("wrap_rise_err", err, 1);
    check("wrap_rise_locked", locked, 0);
    step(9'd1); step(9'd2); step(9'd2); step(9'd1); step(9'd0);
    check("wrap_fall_locked", locked, 1);
    step(9'd511);
    check("wrap_fall_err", err, 1);
    check("wrap_err_cnt", err_cnt, 2);
    for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 9'd0 : 9'd200);
    check("wrap_sync_err_cnt", err_cnt, 2);
    check("wrap_sync_err_count", n_err, 2);
    check("wrap_done_count", n_done, 0);

    // err_cnt saturation.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(9'd0); step(9'd1); step(9'd5);
    end
    check("errsat_pulses", n_err, 260);
    check("errsat_err_cnt", err_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
